// File: rtl/piso_unload_pe_pkg.sv
// Shared constants and state encoding for the PISO unload sequencer.
// Imported by the top and the down-counter sub-module.
package piso_unload_pe_pkg;

  localparam int G_WIDTH   = 8;
  localparam int GAP_CNT_W = 4;

  typedef enum logic [1:0] {
    PISO_IDLE  = 2'd0,
    PISO_SHIFT = 2'd1,
    PISO_GAP   = 2'd2
  } piso_state_e;

  function automatic logic [GAP_CNT_W-1:0] gap_preset(input int gap);
    // The zero flag ends GAP, so the count starts one below the gap length.
    return (gap > 0) ? GAP_CNT_W'(gap - 1) : '0;
  endfunction

endpackage

// File: rtl/piso_down_counter.sv
// Loadable down-counter with clock enable and zero flag.
// Saturates at zero instead of wrapping.
module piso_down_counter
  import piso_unload_pe_pkg::*;
#(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_ena,
  input  logic         i_load,
  input  logic [W-1:0] i_val,
  input  logic         i_dec,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_ena) begin
      if (i_load) begin
        r_cnt <= i_val;
      end else if (i_dec && (r_cnt != '0)) begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/piso_unload_pe.sv
// Parallel-in/serial-out unload sequencer: one word per load/ready
// handshake, shifted out one bit per enabled clock with frame strobes.
module piso_unload_pe
  import piso_unload_pe_pkg::*;
#(
  parameter int WIDTH      = G_WIDTH,
  parameter bit MSB_FIRST  = 1'b1,
  parameter int GAP_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_ena,
  input  logic             load,
  input  logic [WIDTH-1:0] datain,
  output logic             ready,
  output logic             sdo,
  output logic             svalid,
  output logic             sframe,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] BIT_LAST = CW'(WIDTH - 1);
  localparam logic [GAP_CNT_W-1:0] GAP_LAST = gap_preset(GAP_CYCLES);

  piso_state_e      r_state;
  logic [WIDTH-1:0] r_sr;
  logic             r_ready;
  logic             r_sdo;
  logic             r_svalid;
  logic             r_sframe;
  logic             r_done;

  logic             w_accept;
  logic             w_bit_dec;
  logic             w_bit_zero;
  logic             w_gap_load;
  logic             w_gap_dec;
  logic             w_gap_zero;
  logic [WIDTH-1:0] w_sr_next;

  always_comb begin
    w_sr_next = r_sr;
    if (MSB_FIRST) begin
      w_sr_next = {r_sr[WIDTH-2:0], 1'b0};
    end else begin
      w_sr_next = {1'b0, r_sr[WIDTH-1:1]};
    end
  end

  assign w_accept   = (r_state == PISO_IDLE) && load;
  assign w_bit_dec  = (r_state == PISO_SHIFT);
  assign w_gap_load = (r_state == PISO_SHIFT) && w_bit_zero;
  assign w_gap_dec  = (r_state == PISO_GAP);

  piso_down_counter #(
    .W (CW)
  ) u_bit_cnt (
    .clk    (clk),
    .rst    (rst),
    .i_ena  (clk_ena),
    .i_load (w_accept),
    .i_val  (BIT_LAST),
    .i_dec  (w_bit_dec),
    .o_zero (w_bit_zero)
  );

  piso_down_counter #(
    .W (GAP_CNT_W)
  ) u_gap_cnt (
    .clk    (clk),
    .rst    (rst),
    .i_ena  (clk_ena),
    .i_load (w_gap_load),
    .i_val  (GAP_LAST),
    .i_dec  (w_gap_dec),
    .o_zero (w_gap_zero)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= PISO_IDLE;
      r_sr     <= '0;
      r_ready  <= 1'b1;
      r_sdo    <= 1'b0;
      r_svalid <= 1'b0;
      r_sframe <= 1'b0;
      r_done   <= 1'b0;
    end else if (clk_ena) begin
      r_done <= 1'b0;
      unique case (r_state)
        PISO_IDLE: begin
          if (w_accept) begin
            r_sr     <= datain;
            r_sdo    <= MSB_FIRST ? datain[WIDTH-1] : datain[0];
            r_svalid <= 1'b1;
            r_sframe <= 1'b1;
            r_ready  <= 1'b0;
            r_state  <= PISO_SHIFT;
          end
        end
        PISO_SHIFT: begin
          r_sframe <= 1'b0;
          if (w_bit_zero) begin
            r_sr     <= '0;
            r_sdo    <= 1'b0;
            r_svalid <= 1'b0;
            r_done   <= 1'b1;
            if (GAP_CYCLES > 0) begin
              r_state <= PISO_GAP;
            end else begin
              r_state <= PISO_IDLE;
              r_ready <= 1'b1;
            end
          end else begin
            r_sr  <= w_sr_next;
            r_sdo <= MSB_FIRST ? w_sr_next[WIDTH-1] : w_sr_next[0];
          end
        end
        PISO_GAP: begin
          if (w_gap_zero) begin
            r_state <= PISO_IDLE;
            r_ready <= 1'b1;
          end
        end
        default: begin
          r_state <= PISO_IDLE;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign ready  = r_ready;
  assign sdo    = r_sdo;
  assign svalid = r_svalid;
  assign sframe = r_sframe;
  assign done   = r_done;

endmodule

// File: tb/tb_piso_unload_pe.sv
// Directed bench for piso_unload_pe: MSB-first/gap-1 and
// LSB-first/gap-0 instances driven with hand-computed bit sequences.
module tb_piso_unload_pe;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       clk_ena = 1'b1;
  logic       load_m = 1'b0;
  logic       load_l = 1'b0;
  logic [7:0] datain = '0;

  logic m_ready, m_sdo, m_svalid, m_sframe, m_done;
  logic l_ready, l_sdo, l_svalid, l_sframe, l_done;
  logic [4:0] m_o, l_o;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  piso_unload_pe #(
    .WIDTH(8), .MSB_FIRST(1'b1), .GAP_CYCLES(1)
  ) dut (
    .clk(clk), .rst(rst), .clk_ena(clk_ena),
    .load(load_m), .datain(datain),
    .ready(m_ready), .sdo(m_sdo), .svalid(m_svalid),
    .sframe(m_sframe), .done(m_done)
  );

  piso_unload_pe #(
    .WIDTH(8), .MSB_FIRST(1'b0), .GAP_CYCLES(0)
  ) dut_l (
    .clk(clk), .rst(rst), .clk_ena(clk_ena),
    .load(load_l), .datain(datain),
    .ready(l_ready), .sdo(l_sdo), .svalid(l_svalid),
    .sframe(l_sframe), .done(l_done)
  );

  // {ready, svalid, sframe, done, sdo}
  assign m_o = {m_ready, m_svalid, m_sframe, m_done, m_sdo};
  assign l_o = {l_ready, l_svalid, l_sframe, l_done, l_sdo};

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // seq[7] is the first bit expected on sdo.
  task automatic run_frame(input bit sel, input logic [7:0] data,
                           input logic [7:0] seq, input bit hold,
                           input bit last, input string nm);
    logic [4:0] o;
    int nv;
    datain = data;
    if (sel) load_l = 1'b1;
    else load_m = 1'b1;
    tick();
    load_l = 1'b0;
    if (hold) datain = 8'hFF;
    else load_m = 1'b0;
    nv = 0;
    for (int i = 0; i < 8; i++) begin
      o = sel ? l_o : m_o;
      chk($sformatf("%s_sdo%0d", nm, i), 32'(o[0]), 32'(seq[7-i]));
      chk($sformatf("%s_sfr%0d", nm, i), 32'(o[2]), 32'(i == 0));
      chk($sformatf("%s_rdy%0d", nm, i), 32'(o[4]), 32'd0);
      nv += int'(o[3]);
      tick();
    end
    o = sel ? l_o : m_o;
    chk({nm, "_nvalid"}, 32'(nv), 32'd8);
    chk({nm, "_done"}, 32'(o[1]), 32'd1);
    chk({nm, "_sv_end"}, 32'(o[3]), 32'd0);
    chk({nm, "_sdo_end"}, 32'(o[0]), 32'd0);
    chk({nm, "_rdy_done"}, 32'(o[4]), 32'(sel));
    if (last) begin
      tick();
      load_m = 1'b0;
      o = sel ? l_o : m_o;
      chk({nm, "_done_clr"}, 32'(o[1]), 32'd0);
      chk({nm, "_rdy_end"}, 32'(o[4]), 32'd1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    // Reset with load held high
    rst = 1'b0;
    load_m = 1'b1;
    load_l = 1'b1;
    datain = 8'hFF;
    tick();
    tick();
    chk("rst_m", 32'(m_o), 32'b10000);
    chk("rst_l", 32'(l_o), 32'b10000);
    load_m = 1'b0;
    load_l = 1'b0;
    rst = 1'b1;
    tick();
    chk("post_rst", 32'(m_o), 32'b10000);

    run_frame(1'b0, 8'hA5, 8'b10100101, 1'b0, 1'b1, "a5");
    run_frame(1'b1, 8'h01, 8'b10000000, 1'b0, 1'b0, "lsb01");
    // Load during the done cycle with no gap
    run_frame(1'b1, 8'h80, 8'b00000001, 1'b0, 1'b1, "lsb80");
    run_frame(1'b0, 8'hA5, 8'b10100101, 1'b1, 1'b1, "hold");
    tick();
    chk("hold_idle", 32'(m_o), 32'b10000);

    // Clock enable toggling: each bit spans two clocks
    datain = 8'hC3;
    load_m = 1'b1;
    tick();
    load_m = 1'b0;
    for (int i = 0; i < 8; i++) begin
      logic [7:0] s;
      s = 8'b11000011;
      chk($sformatf("ena_a%0d", i), 32'(m_sdo), 32'(s[7-i]));
      clk_ena = 1'b0;
      tick();
      chk($sformatf("ena_b%0d", i), 32'(m_sdo), 32'(s[7-i]));
      chk($sformatf("ena_v%0d", i), 32'(m_svalid), 32'd1);
      clk_ena = 1'b1;
      tick();
    end
    chk("ena_done1", 32'(m_done), 32'd1);
    clk_ena = 1'b0;
    tick();
    chk("ena_done2", 32'(m_done), 32'd1);
    clk_ena = 1'b1;
    tick();
    chk("ena_done3", 32'(m_done), 32'd0);
    chk("ena_rdy", 32'(m_ready), 32'd1);

    // Reset aborts a frame after three bits
    datain = 8'hA5;
    load_m = 1'b1;
    tick();
    load_m = 1'b0;
    chk("ab_b0", 32'(m_sdo), 32'd1);
    tick();
    chk("ab_b1", 32'(m_sdo), 32'd0);
    tick();
    chk("ab_b2", 32'(m_sdo), 32'd1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("ab_idle", 32'(m_o), 32'b10000);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("ab_nodone%0d", i), 32'(m_o), 32'b10000);
    end
    run_frame(1'b0, 8'h3C, 8'b00111100, 1'b0, 1'b1, "3c");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
